// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch controller and its skid buffer.
`default_nettype none

package if_pkg;
  typedef logic [31:2] pc_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } if_ctrl_state_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_ent_t;
endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// Two-entry FIFO between instruction memory and decode; entry 0 is the
// registered head presented to decode.
`default_nettype none

module if_skid_buf
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       push,
  input  fetch_ent_t push_ent,
  input  logic       pop,
  input  logic       flush,
  output fetch_ent_t head,
  output logic [1:0] count
);

  fetch_ent_t ent0, ent1;
  logic       do_pop, do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = ent0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_ent;
          end else begin
            ent0 <= push_ent;
          end
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) ent0 <= push_ent;
          else               ent1 <= push_ent;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_ctrl.sv
// Fetch controller: boot delay, single outstanding read tracking, redirect
// pending/kill handling, and a skid buffer towards decode.
`default_nettype none

module if_ctrl
  import if_pkg::*;
#(
  parameter int BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [31:2] if_pc,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        br_en,
  input  logic [31:2] br_addr,
  input  logic        trap_en,
  input  logic [31:2] trap_addr,
  input  logic        id_ready,
  output logic        if_stall,
  output logic        if_jmp_en,
  output logic [31:2] if_jmp_addr,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:2] id_pc
);

  localparam logic [3:0] BOOT_LAST = (BOOT_DELAY == 0) ? 4'd0 : 4'(BOOT_DELAY - 1);

  if_ctrl_state_t state;
  logic [3:0]     boot_cnt;
  logic           pend, pend_trap, req_kill;
  pc_t            pend_addr, req_pc, evt_addr;
  logic           evt, resp, push, pop, issue;
  logic [1:0]     sb_count, cnt_after;
  fetch_ent_t     push_ent, head;

  // A branch arriving while a trap is pending is not an event at all.
  assign evt      = trap_en | (br_en & ~(pend & pend_trap));
  assign evt_addr = trap_en ? trap_addr : br_addr;
  assign resp     = (state == WAIT) & mem_rvalid;
  assign push     = resp & ~req_kill & ~evt;
  assign pop      = id_valid & id_ready;
  assign push_ent = '{inst: mem_rdata, pc: req_pc};

  always_comb begin
    cnt_after = 2'd0;
    if (!evt) cnt_after = sb_count - {1'b0, pop} + {1'b0, push};
  end

  // Issue only if the response can still be buffered behind what remains.
  assign issue       = ((state == RUN) | resp) & mem_gnt & (cnt_after <= 2'd1);
  assign if_stall    = ~issue;
  assign if_jmp_en   = issue & (evt | pend);
  assign if_jmp_addr = evt ? evt_addr : pend_addr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= BOOT;
      boot_cnt  <= 4'd0;
      pend      <= 1'b0;
      pend_trap <= 1'b0;
      pend_addr <= '0;
      req_kill  <= 1'b0;
      req_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= RUN;
          else                       boot_cnt <= boot_cnt + 4'd1;
        end
        RUN, WAIT: begin
          if (issue)     state <= WAIT;
          else if (resp) state <= RUN;
        end
        default: state <= BOOT;
      endcase

      // The read launched alongside a jump fetched the old PC, so it is wrong-path.
      if (issue) begin
        req_pc   <= if_pc;
        req_kill <= if_jmp_en;
      end else if (evt && (state == WAIT)) begin
        req_kill <= 1'b1;
      end

      if (issue) begin
        pend <= 1'b0;
      end else if (evt) begin
        pend      <= 1'b1;
        pend_trap <= trap_en;
        pend_addr <= evt_addr;
      end
    end
  end

  if_skid_buf u_skid (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .flush    (evt),
    .head     (head),
    .count    (sb_count)
  );

  assign id_valid = (sb_count != 2'd0);
  assign id_inst  = head.inst;
  assign id_pc    = head.pc;

endmodule

`default_nettype wire

// File: tb/tb_if_ctrl.sv
// Scoreboard bench for if_ctrl: memory and if_stage models drive the DUT,
// surviving fetches are queued as expected decode traffic.
`default_nettype none

module tb_if_ctrl;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [31:2] if_pc = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        br_en = 1'b0, trap_en = 1'b0, id_ready = 1'b0;
  logic [31:2] br_addr = '0, trap_addr = '0;
  logic        if_stall, if_jmp_en, id_valid;
  logic [31:2] if_jmp_addr, id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  if_ctrl #(.BOOT_DELAY(2)) dut (
    .clk(clk), .rst_l(rst_l), .if_pc(if_pc),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .br_en(br_en), .br_addr(br_addr), .trap_en(trap_en), .trap_addr(trap_addr),
    .id_ready(id_ready), .if_stall(if_stall), .if_jmp_en(if_jmp_en),
    .if_jmp_addr(if_jmp_addr), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc)
  );

  localparam pc_t RST_PC = 30'h0000_0020;

  int n_vec = 0, n_err = 0, cyc = 0, pops = 0;
  fetch_ent_t exp_q[$];
  pc_t last_pop_pc;

  int gnt_pct = 100, rdy_pct = 100, lat_lo = 1, lat_hi = 1, br_pm = 0, trap_pm = 0;
  logic ov_br = 0, ov_trap = 0, ov_rv = 0;
  pc_t  ov_br_addr, ov_trap_addr;

  pc_t  pc_model = RST_PC, o_pc, owed_addr;
  logic busy = 0, o_kill = 0, owed = 0, owed_trap = 0;
  int   o_due = 0;
  logic last_issue, s_jmp_en, last_idv;
  pc_t  s_jmp_addr;

  function automatic inst_t mem_f(pc_t p);
    return {p, 2'b00} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, then update the reference model.
  task automatic step();
    logic evt, issue;
    pc_t  evt_addr;
    @(negedge clk);
    cyc++;
    if_pc     = pc_model;
    mem_gnt   = ($urandom_range(99) < gnt_pct);
    id_ready  = ($urandom_range(99) < rdy_pct);
    br_en     = ov_br || ($urandom_range(999) < br_pm);
    br_addr   = ov_br ? ov_br_addr : pc_t'($urandom);
    trap_en   = ov_trap || ($urandom_range(999) < trap_pm);
    trap_addr = ov_trap ? ov_trap_addr : pc_t'($urandom);
    mem_rvalid = ov_rv || (busy && cyc == o_due);
    mem_rdata  = (busy && cyc == o_due) ? mem_f(o_pc) : $urandom;
    ov_br = 0; ov_trap = 0; ov_rv = 0;
    #2;
    issue = !if_stall;
    last_issue = issue; s_jmp_en = if_jmp_en; s_jmp_addr = if_jmp_addr; last_idv = id_valid;
    evt      = trap_en || (br_en && !(owed && owed_trap));
    evt_addr = trap_en ? trap_addr : br_addr;
    if (evt) begin
      exp_q.delete();
      o_kill = 1;
      owed = 1; owed_trap = trap_en; owed_addr = evt_addr;
    end
    if (busy && cyc == o_due) begin
      busy = 0;
      if (!o_kill) exp_q.push_back('{inst: mem_f(o_pc), pc: o_pc});
    end
    if (issue) begin
      chk("issue_gnt", mem_gnt, 1);
      chk("issue_idle", busy, 0);
      chk("jmp_en", if_jmp_en, owed);
      if (owed) chk("jmp_addr", if_jmp_addr, owed_addr);
      busy = 1; o_pc = pc_model; o_kill = owed;
      o_due = cyc + int'($urandom_range(lat_hi, lat_lo));
      pc_model = owed ? owed_addr : pc_model + 30'd1;
      owed = 0;
    end else begin
      chk("jmp_when_stall", if_jmp_en, 0);
    end
  endtask

  initial begin : monitor
    fetch_ent_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_l && id_valid && id_ready) begin
        if (exp_q.size() == 0) chk("id_spurious", id_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_inst", id_inst, e.inst);
          last_pop_pc = id_pc;
          pops++;
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, if_stall, 1);
    chk({tag, "_jmp_en"}, if_jmp_en, 0);
    chk({tag, "_jmp_addr"}, if_jmp_addr, 0);
    chk({tag, "_id_valid"}, id_valid, 0);
    chk({tag, "_id_inst"}, id_inst, 0);
    chk({tag, "_id_pc"}, id_pc, 0);
  endtask

  task automatic boot_seq(input string tag);
    step(); chk({tag, "_boot0"}, last_issue, 0);
    step(); chk({tag, "_boot1"}, last_issue, 0); chk({tag, "_boot_idv"}, last_idv, 0);
    step(); chk({tag, "_first_issue"}, last_issue, 1);
  endtask

  task automatic wait_wait_state();
    logic ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (busy && o_due > cyc + 2) ok = 1;
      else step();
    end
    chk("reach_wait", ok, 1);
  endtask

  initial begin : stim
    int p0;
    logic ok;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    @(posedge clk); #2 rst_l = 1'b1;

    // boot, first fetch and 1-cycle-latency streaming
    boot_seq("init");
    step(); step();
    chk("first_pop_pc", last_pop_pc, RST_PC);
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin step(); chk("stream_valid", last_idv, 1); end

    // decode back-pressure fills the buffer and stops issue
    rdy_pct = 0;
    repeat (5) step();
    chk("bp_stall", last_issue, 0);
    chk("bp_valid", last_idv, 1);
    rdy_pct = 100;
    repeat (6) step();

    // branch during an outstanding 3-cycle read
    lat_lo = 3; lat_hi = 3;
    wait_wait_state();
    ov_br = 1; ov_br_addr = 30'h40;
    step();
    p0 = pops; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin step(); ok = (pops != p0); end
    chk("br_pop_seen", ok, 1);
    chk("br_first_pc", last_pop_pc, 30'h40);

    // trap and branch together, later branch ignored
    wait_wait_state();
    ov_trap = 1; ov_trap_addr = 30'h80; ov_br = 1; ov_br_addr = 30'h40;
    step();
    chk("trapbr_addr", s_jmp_addr, 30'h80);
    chk("trapbr_noissue", last_issue, 0);
    ov_br = 1; ov_br_addr = 30'h30;
    step();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = last_issue; end
    chk("trap_win_jmp", s_jmp_en, 1);
    chk("trap_win_addr", s_jmp_addr, 30'h80);
    repeat (10) step();

    // reset mid-WAIT with a redirect pending
    wait_wait_state();
    ov_br = 1; ov_br_addr = 30'h55;
    step();
    rst_l = 1'b0;
    br_en = 0; trap_en = 0; mem_rvalid = 0;
    #1 chk_reset("midrst");
    busy = 0; owed = 0; owed_trap = 0; o_kill = 0; exp_q.delete(); pc_model = RST_PC;
    @(posedge clk); #2 rst_l = 1'b1;
    lat_lo = 1; lat_hi = 1;
    ov_rv = 1;
    boot_seq("rerun");
    repeat (4) step();

    // randomized traffic
    gnt_pct = 70; rdy_pct = 70; lat_lo = 1; lat_hi = 3; br_pm = 40; trap_pm = 15;
    repeat (3000) step();

    // drain
    gnt_pct = 0; rdy_pct = 100; br_pm = 0; trap_pm = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin step(); ok = !busy && exp_q.size() == 0; end
    step();
    chk("drain_empty", ok, 1);
    chk("drain_idv", id_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
